// File: rtl/picomips_sequencer_if.sv
// Sequencer-side bus: pass control, program-memory fetch and datapath strobes.
interface picomips_sequencer_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int I_WIDTH    = 12
);
    logic                  start;
    logic                  abort;
    logic                  dp_ready;
    logic [I_WIDTH-1:0]    instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  acc_clr;
    logic                  mul_en;
    logic                  add_en;
    logic [2:0]            coef_sel;
    logic [2:0]            tap_off;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, abort, dp_ready, instr,
        output pc, acc_clr, mul_en, add_en, coef_sel, tap_off, busy, done, err
    );

    modport slave (
        output start, abort, dp_ready, instr,
        input  pc, acc_clr, mul_en, add_en, coef_sel, tap_off, busy, done, err
    );
endinterface

// File: rtl/picomips_sequencer.sv
// picoMIPS FIR sequencer: fetches 12-bit instructions and issues single-cycle
// MUL/ADD strobes to the datapath, one program pass per start pulse.
module picomips_sequencer #(
    parameter int ADDR_WIDTH = 6,
    parameter int I_WIDTH    = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    picomips_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE, S_ERROR} state_t;

    localparam logic [5:0] OP_NOP = 6'd0;
    localparam logic [5:0] OP_MUL = 6'd1;
    localparam logic [5:0] OP_ADD = 6'd2;
    localparam logic [5:0] OP_END = 6'd3;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [I_WIDTH-1:0]    ir;
    logic                  err, err_n;
    logic                  acc_clr, acc_clr_n;
    logic                  advance;
    logic                  strobe;
    logic [5:0]            op;

    assign op = ir[11:6];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            err     <= 1'b0;
            acc_clr <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            err     <= err_n;
            acc_clr <= acc_clr_n;
            if (state == S_FETCH) ir <= bus.instr;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        err_n     = err;
        acc_clr_n = 1'b0;
        advance   = 1'b0;
        unique case (state)
            S_IDLE: begin
                pc_n = '0;
                if (bus.start && !bus.abort) begin
                    state_n   = S_FETCH;
                    err_n     = 1'b0;
                    acc_clr_n = 1'b1;
                end
            end
            S_FETCH: state_n = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_NOP:         advance = 1'b1;
                    OP_MUL, OP_ADD: advance = bus.dp_ready;
                    OP_END:         state_n = S_DONE;
                    default: begin
                        state_n = S_ERROR;
                        err_n   = 1'b1;
                    end
                endcase
            end
            S_DONE, S_ERROR: begin
                state_n = S_IDLE;
                pc_n    = '0;
            end
            default: state_n = S_IDLE;
        endcase

        // The last address never wraps back into the program; it ends the pass in error.
        if (advance) begin
            if (pc == {ADDR_WIDTH{1'b1}}) begin
                state_n = S_ERROR;
                err_n   = 1'b1;
            end else begin
                state_n = S_FETCH;
                pc_n    = pc + 1'b1;
            end
        end

        if (bus.abort && state != S_IDLE) begin
            state_n   = S_IDLE;
            pc_n      = '0;
            err_n     = err;
            acc_clr_n = 1'b0;
        end
    end

    // Strobes and fields decode from state and ir only, so they hold steady through a stall.
    assign bus.mul_en   = (state == S_EXEC) && (op == OP_MUL);
    assign bus.add_en   = (state == S_EXEC) && (op == OP_ADD);
    assign strobe       = bus.mul_en || bus.add_en;
    assign bus.coef_sel = strobe ? ir[5:3] : 3'd0;
    assign bus.tap_off  = strobe ? ir[2:0] : 3'd0;
    assign bus.busy     = (state == S_FETCH) || (state == S_EXEC) || (state == S_DONE);
    assign bus.done     = (state == S_DONE);
    assign bus.err      = err;
    assign bus.acc_clr  = acc_clr;
    assign bus.pc       = pc;
endmodule

// File: tb/tb_picomips_sequencer.sv
// Bench for picomips_sequencer: per-pass expected traces built from the program,
// ready schedule and abort point, compared against the DUT every cycle.
module tb_picomips_sequencer;
    localparam int AW = 6;
    localparam int IW = 12;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          acc_clr;
        logic          mul_en;
        logic          add_en;
        logic [2:0]    coef_sel;
        logic [2:0]    tap_off;
        logic          busy;
        logic          done;
        logic          err;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    picomips_sequencer_if #(.ADDR_WIDTH(AW), .I_WIDTH(IW)) bus();
    picomips_sequencer #(.ADDR_WIDTH(AW), .I_WIDTH(IW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] prog [64];
    assign bus.instr = prog[bus.pc];

    bit   rdy [1024];
    obs_t exp_q [$];
    obs_t exp_cur;
    obs_t act;
    bit   chk_en = 1'b0;
    bit   m_err  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc, mul_cnt, add_cnt, err_c1;

    assign act = {bus.pc, bus.acc_clr, bus.mul_en, bus.add_en, bus.coef_sel,
                  bus.tap_off, bus.busy, bus.done, bus.err};

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_cur) begin
                errors++;
                $display("FAIL trace cycle %0d: got pc=%0d acc_clr=%b mul=%b add=%b coef=%0d tap=%0d busy=%b done=%b err=%b, want pc=%0d acc_clr=%b mul=%b add=%b coef=%0d tap=%0d busy=%b done=%b err=%b",
                         cyc, act.pc, act.acc_clr, act.mul_en, act.add_en, act.coef_sel, act.tap_off,
                         act.busy, act.done, act.err, exp_cur.pc, exp_cur.acc_clr, exp_cur.mul_en,
                         exp_cur.add_en, exp_cur.coef_sel, exp_cur.tap_off, exp_cur.busy,
                         exp_cur.done, exp_cur.err);
            end
            if (act.done) done_cyc = cyc;
            if (act.mul_en) mul_cnt++;
            if (act.add_en) add_cnt++;
            if (cyc == 1) err_c1 = int'(act.err);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic obs_t mk(int p, bit ac, bit m, bit ad, logic [2:0] cs, logic [2:0] to,
                                bit b, bit d, bit e);
        obs_t r;
        r.pc = p[AW-1:0]; r.acc_clr = ac; r.mul_en = m; r.add_en = ad;
        r.coef_sel = cs; r.tap_off = to; r.busy = b; r.done = d; r.err = e;
        return r;
    endfunction

    function automatic bit rdy_at(int c);
        return (c < 1000) ? rdy[c] : 1'b1;
    endfunction

    // kind: 0 running, 1 aborted, 2 finished on END, 3 ended in error
    task automatic emit(input obs_t r, input int abort_cyc, inout int c, inout int kind);
        exp_q.push_back(r);
        if (c == abort_cyc) kind = 1;
        c++;
    endtask

    task automatic build(input int abort_cyc);
        int c = 1;
        int a = 0;
        int kind = 0;
        bit r;
        logic [IW-1:0] ins;
        int op;
        exp_q.delete();
        while (kind == 0) begin
            ins = prog[a];
            op  = int'(ins[11:6]);
            emit(mk(a, c == 1, 0, 0, 0, 0, 1, 0, 0), abort_cyc, c, kind);
            if (kind != 0) break;
            if (op == 1 || op == 2) begin
                do begin
                    r = rdy_at(c);
                    emit(mk(a, 0, op == 1, op == 2, ins[5:3], ins[2:0], 1, 0, 0), abort_cyc, c, kind);
                end while (kind == 0 && !r);
            end else begin
                emit(mk(a, 0, 0, 0, 0, 0, 1, 0, 0), abort_cyc, c, kind);
            end
            if (kind != 0) break;
            if (op == 3) begin
                emit(mk(a, 0, 0, 0, 0, 0, 1, 1, 0), abort_cyc, c, kind);
                kind = 2;
            end else if (op > 3 || a == 63) begin
                emit(mk(a, 0, 0, 0, 0, 0, 0, 0, 1), abort_cyc, c, kind);
                kind = 3;
            end else begin
                a++;
            end
        end
        m_err = (kind == 3);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, m_err));
    endtask

    // Called in an IDLE cycle (#1 after the edge); leaves the bench in the final IDLE cycle.
    task automatic run_pass(input int abort_cyc, input int rst_cyc);
        int n;
        exp_cur  = mk(0, 0, 0, 0, 0, 0, 0, 0, m_err);
        done_cyc = -1; mul_cnt = 0; add_cnt = 0; err_c1 = -1; cyc = 0;
        bus.start = 1'b1; bus.abort = 1'b0; bus.dp_ready = rdy[0];
        build(abort_cyc);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cyc = i + 1;
            exp_cur = exp_q[i];
            bus.start    = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.dp_ready = rdy_at(cyc);
            bus.abort    = (cyc == abort_cyc);
            if (cyc == rst_cyc) begin
                #2;
                chk_en = 1'b0;
                reset_n = 1'b0;
                #1;
                chk("async_reset_outputs", int'(act), 0);
                bus.start = 1'b0; bus.abort = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                reset_n = 1'b1;
                m_err   = 1'b0;
                exp_cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
                chk_en  = 1'b1;
                return;
            end
        end
    endtask

    task automatic all_ready();
        for (int i = 0; i < 1024; i++) rdy[i] = 1'b1;
    endtask

    task automatic load_nominal();
        prog[0] = {6'd1, 3'd0, 3'b110};
        prog[1] = {6'd2, 6'd0};
        prog[2] = {6'd1, 3'd1, 3'b111};
        prog[3] = {6'd2, 6'd0};
        prog[4] = {6'd1, 3'd2, 3'b000};
        prog[5] = {6'd2, 6'd0};
        prog[6] = {6'd1, 3'd3, 3'b001};
        prog[7] = {6'd2, 6'd0};
        prog[8] = {6'd1, 3'd4, 3'b010};
        prog[9] = {6'd2, 6'd0};
        prog[10] = {6'd3, 6'd0};
        for (int i = 11; i < 64; i++) prog[i] = {6'h3f, 6'd0};
    endtask

    task automatic load_random();
        int len, r;
        len = $urandom_range(1, 20);
        for (int a = 0; a < 64; a++) prog[a] = IW'($urandom);
        for (int a = 0; a < len; a++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      prog[a] = {6'd0, 6'($urandom)};
            else if (r <= 5) prog[a] = {6'd1, 6'($urandom)};
            else if (r <= 8) prog[a] = {6'd2, 6'($urandom)};
            else if ($urandom_range(0, 3) == 0)
                prog[a] = {6'($urandom_range(4, 63)), 6'($urandom)};
            else             prog[a] = {6'd0, 6'd0};
        end
        prog[len] = {6'd3, 6'd0};
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.dp_ready = 1'b0;
        exp_cur = '0;
        load_nominal();
        all_ready();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(act), 0);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // nominal FIR pass
        run_pass(0, 0);
        chk("model_nominal_len", exp_q.size(), 24);
        chk("model_c2_tap", int'(exp_q[1].tap_off), 6);
        chk("model_c23_done", int'(exp_q[22].done), 1);
        chk("nominal_done_cycle", done_cyc, 23);
        chk("nominal_mul_count", mul_cnt, 5);
        chk("nominal_add_count", add_cnt, 5);

        // back-pressure on first MUL
        rdy[2] = 1'b0; rdy[3] = 1'b0; rdy[4] = 1'b0;
        run_pass(0, 0);
        chk("stall_done_cycle", done_cyc, 26);
        chk("stall_mul_count", mul_cnt, 8);
        all_ready();

        // illegal opcode at address 2
        prog[2] = {6'b000111, 6'd0};
        run_pass(0, 0);
        chk("model_illegal_len", exp_q.size(), 8);
        chk("illegal_no_done", done_cyc, -1);
        chk("illegal_err_sticky", int'(bus.err), 1);
        load_nominal();
        run_pass(0, 0);
        chk("err_cleared_c1", err_c1, 0);
        chk("after_err_done_cycle", done_cyc, 23);

        // abort in EXEC of address 4, then during a stall
        run_pass(10, 0);
        chk("abort_no_done", done_cyc, -1);
        chk("abort_pc_zero", int'(bus.pc), 0);
        chk("abort_not_busy", int'(bus.busy), 0);
        for (int i = 6; i < 10; i++) rdy[i] = 1'b0;
        run_pass(8, 0);
        chk("abort_stall_no_done", done_cyc, -1);
        all_ready();

        // start together with abort in IDLE stays idle
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("idle_abort_wins", int'(bus.busy), 0);

        // NOP program without END overruns the PC
        for (int i = 0; i < 64; i++) prog[i] = '0;
        run_pass(0, 0);
        chk("model_overrun_len", exp_q.size(), 130);
        chk("model_overrun_pc", int'(exp_q[128].pc), 63);
        chk("overrun_err", int'(bus.err), 1);

        // asynchronous reset mid-pass, then a clean pass
        load_nominal();
        run_pass(0, 7);
        chk("post_reset_err", int'(bus.err), 0);
        run_pass(0, 0);
        chk("post_reset_done_cycle", done_cyc, 23);

        // randomized programs, back-pressure and aborts
        for (int p = 0; p < 25; p++) begin
            load_random();
            for (int i = 0; i < 1024; i++) rdy[i] = ($urandom_range(0, 99) < 70);
            run_pass(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0, 0);
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/picomips_sequencer.md
# picomips_sequencer

Instruction sequencer for the picoMIPS FIR datapath. Drives the program-memory address, latches each 12-bit instruction, decodes it into single-cycle MUL/ADD strobes with coefficient select and tap offset, and stalls on datapath back-pressure. Runs one program pass per `start` pulse and halts on END. Flags illegal opcodes and PC overrun.

## Interface
- `ADDR_WIDTH`, 6: program-memory address width.
- `I_WIDTH`, 12: instruction width. Format is [11:6] opcode, [5:3] imm, [2:0] offset.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a program pass. Sampled only in IDLE.
- `abort`  in  1  synchronous abort. Returns to IDLE next cycle.
- `dp_ready`  in  1  datapath accepts the current strobe this cycle.
- `instr`  in  I_WIDTH  instruction from program memory (combinational read of `pc`).
- `pc`  out  ADDR_WIDTH  program-memory address.
- `acc_clr`  out  1  clear-accumulator pulse at pass start.
- `mul_en`  out  1  MUL strobe.
- `add_en`  out  1  ADD strobe.
- `coef_sel`  out  3  coefficient index = imm.
- `tap_off`  out  3  signed tap offset (two's complement, −4..+3).
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse on END.
- `err`  out  1  sticky error. Cleared by the next accepted `start`.

## Operation
- States: IDLE, FETCH, EXEC, DONE, ERROR.
- Instruction register: `ir` is loaded from `instr` in FETCH.
- IDLE:
  - `pc`=0.
  - `start`=1 → FETCH, with `acc_clr`=1 for that first FETCH cycle and `err` cleared.
- FETCH:
  - `ir` ← `instr`.
  - → EXEC.
- EXEC, decode of `ir[11:6]`:
  - 0 (NOP): no strobe. `pc`+1 → FETCH. Does not wait for `dp_ready`.
  - 1 (MUL): `mul_en`=1, `coef_sel`=`ir[5:3]`, `tap_off`=`ir[2:0]`. Held until `dp_ready`=1; then `pc`+1 → FETCH.
  - 2 (ADD): `add_en`=1. Held until `dp_ready`=1; then `pc`+1 → FETCH.
  - 3 (END): no strobe → DONE.
  - Any other opcode → ERROR.
- PC overrun: `pc` = 2^ADDR_WIDTH−1 and the instruction there is not END. The instruction completes normally, then → ERROR instead of wrapping.
- DONE: `done`=1 for one cycle → IDLE.
- ERROR: `err`=1, `busy`=0. → IDLE next cycle; `err` stays set.
- `abort`=1 in any non-IDLE state:
  - Next state IDLE, `pc`=0.
  - No `done` pulse. `err` is unchanged.
  - `abort` has priority over `dp_ready` and over END.
- `start` is ignored while `busy`=1. Simultaneous `start` and `abort` in IDLE: `abort` wins, and the FSM stays in IDLE.
- `coef_sel` and `tap_off` are 0 when neither strobe is active.

## Timing
- All outputs are registered or decoded from registered state and `ir`. No combinational path from `instr`, `dp_ready` or `start` to any output.
- Reset (`reset_n`=0, asynchronous): state IDLE, `pc`=0, `ir`=0, and all outputs 0 including `err`. Mid-pass reset aborts immediately with no `done`.
- Throughput with `dp_ready` held 1: 2 cycles per instruction (FETCH + EXEC).
- Each cycle `dp_ready`=0 during a MUL/ADD EXEC adds one cycle. The strobe and its fields stay stable across the stall.
- Latency, with cycle 1 = first cycle after `start` sampled:
  - Instruction k: FETCH in cycle 2k+1, EXEC in cycle 2k+2.
  - `acc_clr` high in cycle 1 only.
- `busy`=1 from cycle 1 through the DONE cycle inclusive.

## Test plan
- Nominal 11-instruction FIR program, `dp_ready`=1, `start` pulse:
  - `acc_clr` in cycle 1.
  - `mul_en` in cycles 2, 6, 10, 14, 18, with `coef_sel`/`tap_off` of 0/−2, 1/−1, 2/0, 3/1, 4/2.
  - `add_en` in cycles 4, 8, 12, 16, 20.
  - `done` in cycle 23; `busy` falls in cycle 24.
- Back-pressure: `dp_ready`=0 for 3 cycles during the first MUL:
  - `mul_en`, `coef_sel`=0 and `tap_off`=−2 held for 4 cycles.
  - `done` in cycle 26.
- Illegal opcode 6'b000111 at address 2:
  - ERROR after the EXEC of address 2; no strobe issued for it.
  - `err`=1, no `done`. A later `start` clears `err` in cycle 1.
- Abort in the EXEC of address 4 (and again in a run during a stall):
  - IDLE next cycle, `pc`=0, no `done`.
  - `start` during `busy` ignored.
- Program of NOPs with no END:
  - `pc` counts 0..63, then ERROR.
  - `err`=1; `pc` never wraps during the pass.
- `reset_n` pulled low asynchronously mid-pass (between clock edges):
  - All outputs 0 immediately.
  - Normal pass resumes on the next `start` after release.
